// File: rtl/issue_scoreboard.sv
// Issue controller between Decode and Execute. It counts in-flight register
// and CC writers, blocks hazards, freezes on GPU stall and holds Fetch while
// a branch is unresolved. All state updates happen on the falling clock edge.
//
//   state   | meaning
//   IDLE    | no branch outstanding, issue allowed
//   BR_WAIT | branch issued, Fetch held until I_BranchResolved
module issue_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic       I_CLOCK,
  input  logic       I_RESET,
  input  logic       I_DE_Valid,
  input  logic [3:0] I_Src1RegIdx,
  input  logic       I_Src1Used,
  input  logic [3:0] I_Src2RegIdx,
  input  logic       I_Src2Used,
  input  logic [3:0] I_DestRegIdx,
  input  logic       I_RegWEn,
  input  logic       I_CCRead,
  input  logic       I_CCWEn,
  input  logic       I_IsBranch,
  input  logic       I_WB_RegWEn,
  input  logic [3:0] I_WB_DestRegIdx,
  input  logic       I_WB_CCWEn,
  input  logic       I_BranchResolved,
  input  logic       I_GPUStallSignal,
  output logic       O_Issue_Signal,
  output logic       O_Stall_Signal,
  output logic       O_Bubble_Signal,
  output logic       O_FetchHold_Signal,
  output logic [4:0] O_InFlight,
  output logic       O_SBError
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, BR_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       reg_cnt_q [NUM_REGS];
  logic [CNT_W-1:0]       reg_cnt_d [NUM_REGS];
  logic [CNT_W-1:0]       cc_cnt_q, cc_cnt_d;
  logic                   err_q, err_d;
  logic [4:0]             inflight_q, inflight_d;
  logic [NUM_REGS-1:0]    reg_inc, reg_dec;
  logic                   cc_inc, cc_dec;
  logic                   hazard;

  // Hazard check uses pre-edge counts, so a same-cycle retire does not bypass.
  always_comb begin
    hazard = (I_Src1Used && (reg_cnt_q[I_Src1RegIdx] != '0))
          || (I_Src2Used && (reg_cnt_q[I_Src2RegIdx] != '0))
          || (I_CCRead   && (cc_cnt_q != '0))
          || (I_RegWEn   && (reg_cnt_q[I_DestRegIdx] == CNT_MAX))
          || (I_CCWEn    && (cc_cnt_q == CNT_MAX));
  end

  // Issue / stall / bubble / fetch-hold decision, same cycle as Decode inputs.
  always_comb begin
    O_Issue_Signal     = I_DE_Valid && !hazard && !I_GPUStallSignal && (state_q == IDLE);
    O_Stall_Signal     = (I_DE_Valid && !O_Issue_Signal) || I_GPUStallSignal;
    O_Bubble_Signal    = !O_Issue_Signal && !I_GPUStallSignal;
    O_FetchHold_Signal = (state_q == BR_WAIT);
  end

  // Per-resource increment (issue) and decrement (retire) requests.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      reg_inc[r] = O_Issue_Signal && I_RegWEn && (I_DestRegIdx == 4'(r));
      reg_dec[r] = I_WB_RegWEn && (I_WB_DestRegIdx == 4'(r));
    end
    cc_inc = O_Issue_Signal && I_CCWEn;
    cc_dec = I_WB_CCWEn;
  end

  // Next counters, branch state, sticky error and post-edge in-flight sum.
  always_comb begin
    reg_cnt_d  = reg_cnt_q;
    cc_cnt_d   = cc_cnt_q;
    state_d    = state_q;
    err_d      = err_q;
    inflight_d = '0;

    for (int r = 0; r < NUM_REGS; r++) begin
      if (reg_dec[r] && !reg_inc[r]) begin
        if (reg_cnt_q[r] == '0) err_d = 1'b1;
        else                    reg_cnt_d[r] = reg_cnt_q[r] - 1'b1;
      end else if (reg_inc[r] && !reg_dec[r]) begin
        reg_cnt_d[r] = reg_cnt_q[r] + 1'b1;
      end
    end

    if (cc_dec && !cc_inc) begin
      if (cc_cnt_q == '0) err_d = 1'b1;
      else                cc_cnt_d = cc_cnt_q - 1'b1;
    end else if (cc_inc && !cc_dec) begin
      cc_cnt_d = cc_cnt_q + 1'b1;
    end

    // GPU stall freezes the FSM; retirements above still proceed.
    if (!I_GPUStallSignal) begin
      case (state_q)
        IDLE: begin
          if (I_BranchResolved) err_d = 1'b1;
          if (O_Issue_Signal && I_IsBranch) state_d = BR_WAIT;
        end
        BR_WAIT: begin
          if (I_BranchResolved) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    inflight_d = 5'(cc_cnt_d);
    for (int r = 0; r < NUM_REGS; r++) begin
      inflight_d = inflight_d + 5'(reg_cnt_d[r]);
    end
  end

  // State registers, updated on the falling edge with the pipeline latches.
  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int r = 0; r < NUM_REGS; r++) reg_cnt_q[r] <= '0;
      cc_cnt_q   <= '0;
      state_q    <= IDLE;
      err_q      <= 1'b0;
      inflight_q <= '0;
    end else begin
      reg_cnt_q  <= reg_cnt_d;
      cc_cnt_q   <= cc_cnt_d;
      state_q    <= state_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
    end
  end

  assign O_InFlight = inflight_q;
  assign O_SBError  = err_q;

endmodule
